load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, default `XLEN (32), datapath width; only 32 is supported.
REQ-002 Parameter: MISALIGN_SPLIT, default 1; 1 = split boundary-crossing accesses into two, 0 = fault them.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present; req_ready  output  1  unit can accept.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  32  effective byte address; req_wdata  input  32  store data; req_rd  input  5  load destination.
REQ-009 mem_address  output  32  word-aligned address to data memory.
REQ-010 mem_WriteData  output  32  lane-aligned store data; mem_wr_en  output  4  byte-lane write strobes.
REQ-011 mem_MemRead  output  1  read enable; mem_load_type  output  2  always 2'b10 (word) when reading.
REQ-012 mem_ReadData  input  32  combinational word read data from memory.
REQ-013 rsp_valid  output  1  one-cycle completion pulse; rsp_data  output  32  load result.
REQ-014 rsp_rd  output  5; rsp_misaligned  output  1; rsp_illegal  output  1.

Function
REQ-015 FSM states IDLE, ACC0, ACC1, RESP; req_ready = (state == IDLE).
REQ-016 Handshake: accept on req_valid && req_ready; capture all req_* in registers; IDLE->ACC0.
REQ-017 mem_* outputs decode only from registered state/request; no combinational path from req_* to mem_*.
REQ-018 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; others illegal.
REQ-019 Illegal: IDLE->RESP, no memory access, rsp_illegal=1, rsp_data=0.
REQ-020 Cross = (offset + size) > 4, offset = addr[1:0], size 1/2/4 bytes.
REQ-021 Cross with MISALIGN_SPLIT=0: IDLE->RESP, no access, rsp_misaligned=1, rsp_data=0; naturally aligned or non-crossing accesses never fault.
REQ-022 ACC0: mem_address = addr & ~3; ACC1: mem_address = (addr & ~3) + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
REQ-023 Store: 8-bit mask = base (0001/0011/1111) << offset; data64 = wdata << 8*offset; ACC0 uses mask[3:0]/data64[31:0], ACC1 uses mask[7:4]/data64[63:32].
REQ-024 Load: mem_MemRead=1, mem_wr_en=0 in ACC0/ACC1; lo word captured at end of ACC0, hi word at end of ACC1.
REQ-025 Load result = ({hi,lo} >> 8*offset) truncated to size, sign-extended for LB/LH, zero-extended for LBU/LHU; hi=0 when no ACC1.
REQ-026 ACC0->ACC1 if cross && MISALIGN_SPLIT else ACC0->RESP; ACC1->RESP; RESP->IDLE.
REQ-027 RESP: rsp_valid=1 for exactly one cycle; rsp_rd = captured rd; stores give rsp_data=0.
REQ-028 Latency accept->rsp_valid: 2 cycles single access, 3 split, 1 fault/illegal; throughput at most one request per latency+1 cycles.
REQ-029 Outside ACC0/ACC1: mem_wr_en=0, mem_MemRead=0, mem_WriteData=0, mem_address=0.
REQ-030 rsp_data/flags held at 0 outside RESP.

Reset
REQ-031 reset_n low immediately forces state IDLE and all outputs 0 (req_ready=1 after release), regardless of clk.
REQ-032 Reset during ACC1 of a split store aborts; first-half bytes already written stay written, and no response is issued.
REQ-033 Request registers clear to 0; no request is accepted while reset_n is low.

Verification
REQ-034 SW addr 0x100 data 0xDEADBEEF -> ACC0 mem_address 0x100, wr_en 1111; rsp_valid 2 cycles after accept.
REQ-035 SB addr 0x103 data 0x000000AA -> wr_en 1000, WriteData 0xAA000000; LBU 0x103 -> 0x000000AA; LB 0x103 -> 0xFFFFFFAA.
REQ-036 Split store: SW 0x102 data 0x11223344 -> ACC0 0x100 wr_en 1100 data 0x33440000; ACC1 0x104 wr_en 0011 data 0x00001122; LW 0x102 -> 0x11223344 after 3 cycles.
REQ-037 With MISALIGN_SPLIT=0, LH at 0x203 -> no memory access, rsp_misaligned=1 one cycle after accept; funct3 011 load -> rsp_illegal=1.
REQ-038 LW at 0xFFFFFFFE -> ACC1 mem_address 0x00000000; reset_n pulsed low in ACC1 -> outputs 0 at once, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-aligned memory port,
// boundary-crossing accesses either split into two word accesses or faulted.
module load_store_unit #(
    parameter int unsigned XLEN           = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_WriteData,
    output logic [3:0]      mem_wr_en,
    output logic            mem_MemRead,
    output logic [1:0]      mem_load_type,
    input  logic [XLEN-1:0] mem_ReadData,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_misaligned,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state_q, state_d;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   addr_q, wdata_q, lo_q, hi_q;
    logic [4:0]        rd_q;
    logic              illegal_q, misal_q;

    function automatic logic legal_f(input logic st, input logic [2:0] f3);
        if (st) return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic cross_f(input logic [1:0] off, input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return ({1'b0, off} + sz) > 3'd4;
    endfunction

    logic accept_c, req_legal_c, req_cross_c, cross_q_c;
    assign accept_c    = req_valid && req_ready;
    assign req_legal_c = legal_f(req_is_store, req_funct3);
    assign req_cross_c = cross_f(req_addr[1:0], req_funct3);
    assign cross_q_c   = cross_f(addr_q[1:0], funct3_q);

    // Lane alignment of store data/strobes and of the two-word load window
    logic [3:0]        base_c;
    logic [7:0]        mask8_c;
    logic [2*XLEN-1:0] data64_c, ld64_c;
    logic [XLEN-1:0]   load_c, word_addr_c;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   base_c = 4'b0001;
            2'b01:   base_c = 4'b0011;
            default: base_c = 4'b1111;
        endcase
        mask8_c     = {4'b0000, base_c} << addr_q[1:0];
        data64_c    = {XLEN'(0), wdata_q} << {addr_q[1:0], 3'b000};
        ld64_c      = {hi_q, lo_q} >> {addr_q[1:0], 3'b000};
        word_addr_c = {addr_q[XLEN-1:2], 2'b00};
        case (funct3_q)
            3'b000:  load_c = {{(XLEN-8){ld64_c[7]}}, ld64_c[7:0]};
            3'b001:  load_c = {{(XLEN-16){ld64_c[15]}}, ld64_c[15:0]};
            3'b100:  load_c = {(XLEN-8)'(0), ld64_c[7:0]};
            3'b101:  load_c = {(XLEN-16)'(0), ld64_c[15:0]};
            default: load_c = ld64_c[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        mem_address    = '0;
        mem_WriteData  = '0;
        mem_wr_en      = 4'b0000;
        mem_MemRead    = 1'b0;
        mem_load_type  = 2'b00;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_rd         = 5'd0;
        rsp_misaligned = 1'b0;
        rsp_illegal    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = reset_n;
                if (accept_c) begin
                    if (!req_legal_c || (req_cross_c && !MISALIGN_SPLIT)) state_d = RESP;
                    else                                                  state_d = ACC0;
                end
            end
            ACC0: begin
                state_d     = (cross_q_c && MISALIGN_SPLIT) ? ACC1 : RESP;
                mem_address = word_addr_c;
                if (is_store_q) begin
                    mem_wr_en     = mask8_c[3:0];
                    mem_WriteData = data64_c[XLEN-1:0];
                end else begin
                    mem_MemRead   = 1'b1;
                    mem_load_type = 2'b10;
                end
            end
            ACC1: begin
                state_d     = RESP;
                mem_address = word_addr_c + XLEN'(4);
                if (is_store_q) begin
                    mem_wr_en     = mask8_c[7:4];
                    mem_WriteData = data64_c[2*XLEN-1:XLEN];
                end else begin
                    mem_MemRead   = 1'b1;
                    mem_load_type = 2'b10;
                end
            end
            RESP: begin
                state_d        = IDLE;
                rsp_valid      = 1'b1;
                rsp_rd         = rd_q;
                rsp_misaligned = misal_q;
                rsp_illegal    = illegal_q;
                if (!is_store_q && !illegal_q && !misal_q) rsp_data = load_c;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and load-word collection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            illegal_q  <= 1'b0;
            misal_q    <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else if (accept_c) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
            illegal_q  <= !req_legal_c;
            misal_q    <= req_legal_c && req_cross_c && !MISALIGN_SPLIT;
            lo_q       <= '0;
            hi_q       <= '0;
        end else if (state_q == ACC0 && !is_store_q) begin
            lo_q <= mem_ReadData;
        end else if (state_q == ACC1 && !is_store_q) begin
            hi_q <= mem_ReadData;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a split-mode instance with a byte-lane
// memory model, and a fault-mode instance reading a constant word.
module tb_load_store_unit;

    logic        clk, reset_n;
    logic        req_valid, ns_req_valid;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;

    logic        req_ready, mem_MemRead, rsp_valid, rsp_misaligned, rsp_illegal;
    logic [31:0] mem_address, mem_WriteData, mem_ReadData, rsp_data;
    logic [3:0]  mem_wr_en;
    logic [1:0]  mem_load_type;
    logic [4:0]  rsp_rd;

    logic        ns_req_ready, ns_mem_MemRead, ns_rsp_valid, ns_rsp_misaligned, ns_rsp_illegal;
    logic [31:0] ns_mem_address, ns_mem_WriteData, ns_mem_ReadData, ns_rsp_data;
    logic [3:0]  ns_mem_wr_en;
    logic [1:0]  ns_mem_load_type;
    logic [4:0]  ns_rsp_rd;

    logic [31:0] mem [256];

    load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(mem_address), .mem_WriteData(mem_WriteData), .mem_wr_en(mem_wr_en),
        .mem_MemRead(mem_MemRead), .mem_load_type(mem_load_type), .mem_ReadData(mem_ReadData),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal)
    );

    load_store_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .reset_n(reset_n),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(ns_mem_address), .mem_WriteData(ns_mem_WriteData), .mem_wr_en(ns_mem_wr_en),
        .mem_MemRead(ns_mem_MemRead), .mem_load_type(ns_mem_load_type), .mem_ReadData(ns_mem_ReadData),
        .rsp_valid(ns_rsp_valid), .rsp_data(ns_rsp_data), .rsp_rd(ns_rsp_rd),
        .rsp_misaligned(ns_rsp_misaligned), .rsp_illegal(ns_rsp_illegal)
    );

    always #5 clk = ~clk;

    assign mem_ReadData    = mem[mem_address[9:2]];
    assign ns_mem_ReadData = 32'hCAFEF00D;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wr_en[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_WriteData[8*b +: 8];
    end

    // Observation mux onto whichever instance the current vector targets
    logic        sel;
    logic        o_rv, o_ready, o_rd_en, o_mis, o_ill;
    logic [31:0] o_addr, o_wd, o_data;
    logic [3:0]  o_we;
    logic [1:0]  o_lt;
    logic [4:0]  o_rd;
    always_comb begin
        o_rv    = sel ? ns_rsp_valid      : rsp_valid;
        o_ready = sel ? ns_req_ready      : req_ready;
        o_rd_en = sel ? ns_mem_MemRead    : mem_MemRead;
        o_mis   = sel ? ns_rsp_misaligned : rsp_misaligned;
        o_ill   = sel ? ns_rsp_illegal    : rsp_illegal;
        o_addr  = sel ? ns_mem_address    : mem_address;
        o_wd    = sel ? ns_mem_WriteData  : mem_WriteData;
        o_data  = sel ? ns_rsp_data       : rsp_data;
        o_we    = sel ? ns_mem_wr_en      : mem_wr_en;
        o_lt    = sel ? ns_mem_load_type  : mem_load_type;
        o_rd    = sel ? ns_rsp_rd         : rsp_rd;
    end

    typedef struct {
        logic        ns;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill, mis;
        int          lat, nacc;
        logic [31:0] a0;
        logic [3:0]  we0;
        logic [31:0] wd0, a1;
        logic [3:0]  we1;
        logic [31:0] wd1;
    } vec_t;

    localparam int unsigned NV = 26;
    vec_t vecs[NV];
    int   n_pass, n_total;

    function automatic vec_t mk(input logic ns, st, input logic [2:0] f3,
                                input logic [31:0] addr, wdata, input logic [4:0] rd,
                                input logic [31:0] data, input logic ill, mis,
                                input int lat, nacc,
                                input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] wd0,
                                input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] wd1);
        vec_t v;
        v.ns = ns; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.data = data; v.ill = ill; v.mis = mis; v.lat = lat; v.nacc = nacc;
        v.a0 = a0; v.we0 = we0; v.wd0 = wd0; v.a1 = a1; v.we1 = we1; v.wd1 = wd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        sel = v.ns; req_is_store = v.st; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        if (v.ns) ns_req_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; ns_req_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat, n;
        logic [31:0] a[2], wd[2];
        logic [3:0]  we[2];
        a = '{32'hX, 32'hX}; wd = '{32'hX, 32'hX}; we = '{4'hX, 4'hX};
        drive(v);
        lat = 1; n = 0;
        while (!o_rv && lat < 10) begin
            if (o_rd_en || o_we != 4'b0000) begin
                if (n < 2) begin a[n] = o_addr; we[n] = o_we; wd[n] = o_wd; end
                if (o_rd_en) chk({tag, "_ltype"}, 32'(o_lt), 32'(2'b10));
                n++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'(v.lat));
        chk({tag, "_nacc"}, 32'(n),   32'(v.nacc));
        chk({tag, "_data"}, o_data,   v.data);
        chk({tag, "_rd"},   32'(o_rd), 32'(v.rd));
        chk({tag, "_flags"}, {30'd0, o_ill, o_mis}, {30'd0, v.ill, v.mis});
        if (v.nacc >= 1) begin
            chk({tag, "_a0"},  a[0], v.a0);
            chk({tag, "_we0"}, 32'(we[0]), 32'(v.we0));
            chk({tag, "_wd0"}, wd[0], v.wd0);
        end
        if (v.nacc == 2) begin
            chk({tag, "_a1"},  a[1], v.a1);
            chk({tag, "_we1"}, 32'(we[1]), 32'(v.we1));
            chk({tag, "_wd1"}, wd[1], v.wd1);
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, o_rv}, 32'd0);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    // Reset asserted mid-ACC1: outputs drop at once and no response follows
    task automatic abort_seq(input string tag, input logic st, input logic [31:0] addr, wdata,
                             input logic [31:0] exp_a1, input logic [3:0] exp_we1, input logic [31:0] exp_wd1);
        int seen;
        drive(mk(1'b0, st, 3'b010, addr, wdata, 5'd31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk({tag, "_acc1_addr"}, mem_address, exp_a1);
        chk({tag, "_acc1_we"},   32'(mem_wr_en), 32'(exp_we1));
        chk({tag, "_acc1_wd"},   mem_WriteData, exp_wd1);
        chk({tag, "_acc1_rden"}, {31'd0, mem_MemRead}, {31'd0, !st});
        reset_n = 1'b0;
        #1;
        chk({tag, "_rst_addr"}, mem_address, 32'd0);
        chk({tag, "_rst_ctl"}, {25'd0, mem_wr_en, mem_MemRead, mem_load_type}, 32'd0);
        chk({tag, "_rst_wd"},  mem_WriteData, 32'd0);
        chk({tag, "_rst_rsp"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rst_ready"}, {31'd0, req_ready}, 32'd0);
        #3;
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
        chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b1; sel = 1'b0;
        req_valid = 1'b0; ns_req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        n_pass = 0; n_total = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        //            ns    st    f3      addr          wdata         rd     data          ill   mis lat nacc a0            we0     wd0           a1            we1     wd1
        vecs[0]  = mk(1'b0, 1'b1, 3'b010, 32'h100,      32'hDEADBEEF, 5'd1,  32'h0,        0, 0, 2, 1, 32'h100,      4'hF, 32'hDEADBEEF, 0, 0, 0);
        vecs[1]  = mk(1'b0, 1'b0, 3'b010, 32'h100,      32'h0,        5'd2,  32'hDEADBEEF, 0, 0, 2, 1, 32'h100,      4'h0, 32'h0,        0, 0, 0);
        vecs[2]  = mk(1'b0, 1'b1, 3'b000, 32'h103,      32'h000000AA, 5'd3,  32'h0,        0, 0, 2, 1, 32'h100,      4'h8, 32'hAA000000, 0, 0, 0);
        vecs[3]  = mk(1'b0, 1'b0, 3'b100, 32'h103,      32'h0,        5'd4,  32'h000000AA, 0, 0, 2, 1, 32'h100,      4'h0, 32'h0,        0, 0, 0);
        vecs[4]  = mk(1'b0, 1'b0, 3'b000, 32'h103,      32'h0,        5'd5,  32'hFFFFFFAA, 0, 0, 2, 1, 32'h100,      4'h0, 32'h0,        0, 0, 0);
        vecs[5]  = mk(1'b0, 1'b0, 3'b001, 32'h100,      32'h0,        5'd6,  32'hFFFFBEEF, 0, 0, 2, 1, 32'h100,      4'h0, 32'h0,        0, 0, 0);
        vecs[6]  = mk(1'b0, 1'b0, 3'b101, 32'h102,      32'h0,        5'd7,  32'h0000AAAD, 0, 0, 2, 1, 32'h100,      4'h0, 32'h0,        0, 0, 0);
        vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h102,      32'h11223344, 5'd8,  32'h0,        0, 0, 3, 2, 32'h100,      4'hC, 32'h33440000, 32'h104, 4'h3, 32'h00001122);
        vecs[8]  = mk(1'b0, 1'b0, 3'b010, 32'h102,      32'h0,        5'd9,  32'h11223344, 0, 0, 3, 2, 32'h100,      4'h0, 32'h0,        32'h104, 4'h0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 3'b001, 32'h107,      32'h0000CAFE, 5'd10, 32'h0,        0, 0, 3, 2, 32'h104,      4'h8, 32'hFE000000, 32'h108, 4'h1, 32'h000000CA);
        vecs[10] = mk(1'b0, 1'b0, 3'b101, 32'h107,      32'h0,        5'd11, 32'h0000CAFE, 0, 0, 3, 2, 32'h104,      4'h0, 32'h0,        32'h108, 4'h0, 32'h0);
        vecs[11] = mk(1'b0, 1'b0, 3'b001, 32'h107,      32'h0,        5'd12, 32'hFFFFCAFE, 0, 0, 3, 2, 32'h104,      4'h0, 32'h0,        32'h108, 4'h0, 32'h0);
        vecs[12] = mk(1'b0, 1'b0, 3'b000, 32'h105,      32'h0,        5'd13, 32'h00000011, 0, 0, 2, 1, 32'h104,      4'h0, 32'h0,        0, 0, 0);
        vecs[13] = mk(1'b0, 1'b0, 3'b011, 32'h100,      32'h0,        5'd14, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1'b0, 1'b1, 3'b100, 32'h100,      32'h12345678, 5'd15, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1'b0, 1'b0, 3'b110, 32'h100,      32'h0,        5'd16, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h55667788, 5'd17, 32'h0,        0, 0, 2, 1, 32'hFFFFFFFC, 4'hF, 32'h55667788, 0, 0, 0);
        vecs[17] = mk(1'b0, 1'b1, 3'b010, 32'h0,        32'h99AABBCC, 5'd18, 32'h0,        0, 0, 2, 1, 32'h0,        4'hF, 32'h99AABBCC, 0, 0, 0);
        vecs[18] = mk(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        5'd19, 32'hBBCC5566, 0, 0, 3, 2, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h0, 4'h0, 32'h0);
        vecs[19] = mk(1'b1, 1'b0, 3'b001, 32'h203,      32'h0,        5'd20, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[20] = mk(1'b1, 1'b0, 3'b010, 32'h204,      32'h0,        5'd21, 32'hCAFEF00D, 0, 0, 2, 1, 32'h204,      4'h0, 32'h0,        0, 0, 0);
        vecs[21] = mk(1'b1, 1'b1, 3'b001, 32'h202,      32'h0000BEEF, 5'd22, 32'h0,        0, 0, 2, 1, 32'h200,      4'hC, 32'hBEEF0000, 0, 0, 0);
        vecs[22] = mk(1'b1, 1'b1, 3'b010, 32'h201,      32'h12345678, 5'd23, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[23] = mk(1'b1, 1'b0, 3'b000, 32'h203,      32'h0,        5'd24, 32'hFFFFFFCA, 0, 0, 2, 1, 32'h200,      4'h0, 32'h0,        0, 0, 0);
        vecs[24] = mk(1'b1, 1'b0, 3'b011, 32'h200,      32'h0,        5'd25, 32'h0,        1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[25] = mk(1'b1, 1'b0, 3'b010, 32'h206,      32'h0,        5'd26, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready",    {31'd0, req_ready}, 32'd0);
        chk("rst_ns_ready", {31'd0, ns_req_ready}, 32'd0);
        chk("rst_mem",      {25'd0, mem_wr_en, mem_MemRead, mem_load_type}, 32'd0);
        chk("rst_addr",     mem_address, 32'd0);
        chk("rst_rsp",      {30'd0, rsp_valid, ns_rsp_valid}, 32'd0);
        #19 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_data",  rsp_data, 32'd0);

        for (int i = 0; i < NV; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        sel = 1'b0;
        abort_seq("abort_st", 1'b1, 32'h10A, 32'h01020304, 32'h10C, 4'h3, 32'h00000102);
        run_vec("after_st_lo", mk(1'b0, 1'b0, 3'b010, 32'h108, 32'h0, 5'd27, 32'h030400CA, 0, 0, 2, 1, 32'h108, 4'h0, 32'h0, 0, 0, 0));
        run_vec("after_st_hi", mk(1'b0, 1'b0, 3'b010, 32'h10C, 32'h0, 5'd28, 32'h0,        0, 0, 2, 1, 32'h10C, 4'h0, 32'h0, 0, 0, 0));
        abort_seq("abort_ld", 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 4'h0, 32'h0);
        run_vec("after_ld", mk(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd29, 32'h3344BEEF, 0, 0, 2, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
